// File: rtl/keypad_event_ctrl_if.sv
// Output event stream of the keypad event controller: show-ahead head code
// with a valid/ready handshake toward the consumer.
interface keypad_event_ctrl_if;
    logic [3:0] out_code;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_code, output out_valid, input out_ready);
    modport slave  (input out_code, input out_valid, output out_ready);
endinterface

// File: rtl/keypad_event_ctrl.sv
// Keypad event controller: debounces scanner strobes into one event per press,
// enforces release-before-next-press and queues codes in a show-ahead FIFO.
module keypad_event_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          key_strobe,
    input  logic [3:0]                    key_code,
    input  logic                          key_down,
    keypad_event_ctrl_if.master           out_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          held,
    output logic                          overflow,
    input  logic                          clear_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [7:0]    CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_cnt, w_cnt_nxt;
    logic [3:0]    r_cand, w_cand_nxt;
    logic          w_push;
    logic          r_held;
    logic          r_ovf;

    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_valid, w_full, w_pop, w_do_push, w_ovf_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
            r_held  <= (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_strobe && key_down) begin
                    w_cand_nxt  = key_code;
                    w_cnt_nxt   = 8'd1;
                    w_state_nxt = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!key_down) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (key_strobe && (key_code != r_cand)) begin
                    w_cand_nxt = key_code;
                    w_cnt_nxt  = 8'd1;
                end else if (r_cnt == CNT_LAST) begin
                    w_push      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PRESSED;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_PRESSED: begin
                if (!key_down) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = 8'd1;
                end
            end
            S_RELEASE: begin
                if (key_down) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = w_valid && out_if.out_ready;
    assign w_do_push = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= r_cand;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign out_if.out_valid = w_valid;
    assign out_if.out_code  = w_valid ? r_mem[r_rd_ptr] : 4'h0;
    assign fifo_count       = r_count;
    assign held             = r_held;
    assign overflow         = r_ovf;
endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Scoreboard bench for keypad_event_ctrl: stimulus queues expected codes,
// a negedge monitor checks every accepted head against the queue.
module tb_keypad_event_ctrl;
    logic       clock;
    logic       reset;
    logic       key_strobe;
    logic [3:0] key_code;
    logic       key_down;
    logic [2:0] fifo_count;
    logic       held;
    logic       overflow;
    logic       clear_ovf;

    keypad_event_ctrl_if ifc ();

    keypad_event_ctrl #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_strobe (key_strobe),
        .key_code   (key_code),
        .key_down   (key_down),
        .out_if     (ifc.master),
        .fifo_count (fifo_count),
        .held       (held),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [3:0]  exp_q [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected code.
    always @(negedge clock) begin
        if (!reset) begin
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'(ifc.out_code), 32'hFF);
                end else begin
                    chk("pop_code", 32'(ifc.out_code), 32'(exp_q.pop_front()));
                end
            end else if (!ifc.out_valid) begin
                chk("code_gated", 32'(ifc.out_code), 0);
            end
        end
    end

    // One full press: strobe in cycle 0, push lands on the edge ending cycle 3,
    // release starts in cycle 5 and takes 4 cycles, then one idle cycle.
    task automatic press(input logic [3:0] code, input bit exp_push, input bit rdy, input bit clr);
        key_strobe = 1'b1;
        key_code   = code;
        key_down   = 1'b1;
        if (exp_push) exp_q.push_back(code);
        tick();
        key_strobe = 1'b0;
        tick();
        tick();
        out_ready_set(rdy);
        clear_ovf = clr;
        tick();
        out_ready_set(1'b0);
        clear_ovf = 1'b0;
        tick();
        key_down = 1'b0;
        repeat (5) tick();
    endtask

    task automatic out_ready_set(input logic v);
        ifc.out_ready = v;
    endtask

    task automatic drain(input int unsigned n);
        out_ready_set(1'b1);
        repeat (n) tick();
        out_ready_set(1'b0);
        chk("drain_count", 32'(fifo_count), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; key_strobe = 1'b0; key_code = 4'h0; key_down = 1'b0;
        clear_ovf = 1'b0; ifc.out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", 32'(ifc.out_valid), 0);
        chk("rst_code", 32'(ifc.out_code), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_held", 32'(held), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // Clean press of A: high cycles 0..9, low cycles 10..15.
        key_strobe = 1'b1; key_code = 4'hA; key_down = 1'b1;
        exp_q.push_back(4'hA);
        for (int c = 1; c <= 15; c++) begin
            tick();
            key_strobe = 1'b0;
            if (c == 10) key_down = 1'b0;
            chk("clean_valid", 32'(ifc.out_valid), (c >= 4) ? 1 : 0);
            chk("clean_held", 32'(held), (c >= 4 && c <= 13) ? 1 : 0);
        end
        chk("clean_head", 32'(ifc.out_code), 32'hA);
        chk("clean_count", 32'(fifo_count), 1);
        drain(1);

        // Press bounce: first burst never completes debounce.
        key_strobe = 1'b1; key_code = 4'h3; key_down = 1'b1;
        tick();
        key_strobe = 1'b0;
        tick();
        key_down = 1'b0;
        tick();
        chk("bounce_nopush", 32'(fifo_count), 0);
        key_strobe = 1'b1; key_down = 1'b1;
        exp_q.push_back(4'h3);
        tick();
        key_strobe = 1'b0;
        tick(); tick();
        chk("bounce_early", 32'(fifo_count), 0);
        tick();
        chk("bounce_push", 32'(fifo_count), 1);
        repeat (3) tick();
        chk("bounce_single", 32'(fifo_count), 1);
        key_down = 1'b0;
        repeat (5) tick();
        drain(1);

        // Release bounce on 5, stray strobe of 6 during release, then real 6.
        key_strobe = 1'b1; key_code = 4'h5; key_down = 1'b1;
        exp_q.push_back(4'h5);
        tick();
        key_strobe = 1'b0;
        repeat (3) tick();
        chk("rel_count1", 32'(fifo_count), 1);
        key_down = 1'b0;
        for (int c = 5; c <= 11; c++) begin
            tick();
            key_down = (c == 6) ? 1'b1 : 1'b0;
            key_strobe = (c == 9) ? 1'b1 : 1'b0;
            key_code = (c == 9) ? 4'h6 : 4'h5;
            chk("rel_held", 32'(held), (c <= 10) ? 1 : 0);
        end
        chk("rel_nodup", 32'(fifo_count), 1);
        press(4'h6, 1'b1, 1'b0, 1'b0);
        chk("rel_count2", 32'(fifo_count), 2);
        drain(2);

        // Fill and overflow: fifth press is dropped.
        for (int k = 1; k <= 4; k++) press(4'(k), 1'b1, 1'b0, 1'b0);
        chk("fill_count", 32'(fifo_count), 4);
        chk("fill_noovf", 32'(overflow), 0);
        press(4'h5, 1'b0, 1'b0, 1'b0);
        chk("ovf_count", 32'(fifo_count), 4);
        chk("ovf_set", 32'(overflow), 1);
        drain(4);
        chk("ovf_sticky", 32'(overflow), 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Full FIFO with pop on the push edge: B becomes the tail.
        for (int k = 7; k <= 10; k++) press(4'(k), 1'b1, 1'b0, 1'b0);
        press(4'hB, 1'b1, 1'b1, 1'b0);
        chk("simul_count", 32'(fifo_count), 4);
        chk("simul_noovf", 32'(overflow), 0);
        // Overflow set coinciding with clear: set wins.
        press(4'hC, 1'b0, 1'b0, 1'b1);
        chk("set_wins", 32'(overflow), 1);
        drain(4);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;

        // Reset during debounce discards the candidate.
        key_strobe = 1'b1; key_code = 4'hF; key_down = 1'b1;
        tick();
        key_strobe = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_valid", 32'(ifc.out_valid), 0);
        chk("mid_rst_held", 32'(held), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        key_down = 1'b0;
        tick();
        press(4'hF, 1'b1, 1'b0, 1'b0);
        chk("fresh_count", 32'(fifo_count), 1);
        drain(1);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_event_ctrl.md
Name: keypad_event_ctrl

Overview:
Sits between the hex keypad scanner and the consuming logic (CPU bus, display driver).
- Debounces scanner key strobes into one clean event per physical press.
- Enforces release-before-next-press.
- Queues accepted 4-bit codes in a small show-ahead FIFO drained by a valid/ready handshake.
- Reports overflow and key-held status.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clock cycles key_down must stay stable to accept a press or a release; legal range 2..255.
- FIFO_DEPTH, 4: event queue entries; power of two, at least 2.

Ports:
- clock, input, 1: rising-edge clock shared with the scanner.
- reset, input, 1: synchronous, active-high.
- key_strobe, input, 1: one-cycle pulse from the scanner; key_code is valid this cycle.
- key_code, input, 4: hex code of the detected key.
- key_down, input, 1: level; high while any row line is active (OR of rows).
- out_code, output, 4: code at FIFO head; 4'h0 when out_valid=0.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer accepts head when high with out_valid.
- fifo_count, output, log2(FIFO_DEPTH)+1: occupied entries (3 bits at default).
- held, output, 1: a debounced key is currently pressed (PRESSED or RELEASE state).
- overflow, output, 1: sticky; an accepted press was dropped because the FIFO was full.
- clear_ovf, input, 1: clears overflow.

Behaviour:
- Reset (synchronous, high at rising edge): state=IDLE, debounce counter=0, candidate code=0, FIFO empty (pointers 0), fifo_count=0, out_valid=0, out_code=0, held=0, overflow=0. Reset mid-debounce or mid-press discards the candidate; no push occurs.
- Debounce counter width: 8 bits.
- IDLE:
  - key_strobe=1 and key_down=1: latch candidate=key_code, cnt=1, go to DEBOUNCE.
  - key_strobe with key_down=0: ignored.
- DEBOUNCE:
  - key_down=0: go to IDLE, cnt=0.
  - key_strobe=1 with key_code different from candidate: relatch candidate, cnt=1, stay in DEBOUNCE.
  - Otherwise with key_down=1: if cnt==DEBOUNCE_CYCLES-1, push candidate and go to PRESSED; else cnt+1.
  - Latency: strobe at cycle 0 with key_down held high gives the push on the edge ending cycle DEBOUNCE_CYCLES-1. out_valid rises in cycle DEBOUNCE_CYCLES (cycle 4 at default).
- PRESSED:
  - key_down=0: go to RELEASE, cnt=1.
  - Strobes ignored; no autorepeat, no rollover.
- RELEASE:
  - key_down=1: return to PRESSED (release bounce), cnt=0.
  - key_down=0: if cnt==DEBOUNCE_CYCLES-1, go to IDLE; else cnt+1.
  - Strobes ignored.
- held=1 in PRESSED and RELEASE, registered from state.
- FIFO:
  - Show-ahead: out_code is the head entry combinationally from storage, gated to 0 when empty.
  - pop = out_valid & out_ready.
  - Push when not full: write at wr_ptr, wr_ptr+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Push and pop in the same cycle while full: pop frees the slot, push is accepted, count stays FIFO_DEPTH.
  - Push and pop in the same cycle while empty: the pop is not valid (out_valid=0), so only the push happens.
- Push while full without a simultaneous pop: code dropped, overflow set on that edge. The FSM still goes to PRESSED.
- overflow:
  - Cleared by clear_ovf=1.
  - A set event coinciding with clear_ovf: set wins.
- out_ready while out_valid=0: no effect.

Test Plan:
- Clean press: reset; strobe code 4'hA with key_down high for 10 cycles, then low for 6. Expect out_valid rises exactly 4 cycles after the strobe, out_code=4'hA, held=1 from cycle 4 until 4 cycles after key_down falls, exactly one entry.
- Press bounce: strobe 4'h3, key_down high 2 cycles, low 1 cycle, then strobe 4'h3 again and hold high. Expect no push from the first burst and a single push of 4'h3 4 cycles after the second strobe.
- Release bounce: after an accepted 4'h5, key_down low 2 cycles, high 1, low 5; then strobe 4'h6. Expect held remains 1 through the glitch, no duplicate 4'h5, and 4'h6 accepted only after the full release debounce.
- Fill and overflow: out_ready=0; accept five distinct presses 1,2,3,4,5. Expect fifo_count=4, overflow=1 after the fifth, and the queue drains 1,2,3,4 in order with out_ready=1.
- Simultaneous push/pop while full: FIFO full, out_ready=1 on the push edge. Expect count stays 4, overflow stays 0, the new code becomes the tail. Then clear_ovf pulsed alone clears a previously set flag.
- Reset mid-debounce: strobe 4'hF, assert reset at cycle 2 for one cycle, key_down held high. Expect state IDLE, no push, all outputs 0 until a fresh strobe.
